// File: rtl/vx_commit_pkg.sv
// Shared types for the commit stage: one commit beat as a packed struct, plus
// the thread-mask population count used by the retired-instruction counter.
package vx_commit_pkg;

  localparam int NUM_THREADS = 4;
  localparam int XLEN        = 32;
  localparam int NW_BITS     = 2;
  localparam int NR_BITS     = 6;
  localparam int UUID_BITS   = 44;

  typedef struct packed {
    logic [UUID_BITS-1:0]        uuid;
    logic [NW_BITS-1:0]          wid;
    logic [NUM_THREADS-1:0]      tmask;
    logic [XLEN-1:0]             PC;
    logic [NUM_THREADS*XLEN-1:0] data;
    logic [NR_BITS-1:0]          rd;
    logic                        wb;
    logic                        eop;
  } commit_t;

  localparam int COMMIT_W = $bits(commit_t);

  function automatic logic [63:0] popcount_tmask(input logic [NUM_THREADS-1:0] tmask);
    logic [63:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      cnt = cnt + 64'(tmask[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/vx_rr_arbiter.sv
// Combinational round-robin arbiter: the request just after ptr has highest
// priority. The pointer register lives in the parent so it only moves on a fire.
module vx_rr_arbiter #(
  parameter int NUM_REQS = 4,
  localparam int IDX_W   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic [NUM_REQS-1:0] req,
  input  logic [IDX_W-1:0]    ptr,
  output logic [NUM_REQS-1:0] grant,
  output logic [IDX_W-1:0]    grant_idx
);

  int   idx;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_REQS; i++) begin
      idx = (int'(ptr) + 1 + i) % NUM_REQS;
      if (!found && req[idx]) begin
        found          = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/vx_commit_arb.sv
// Commit arbiter: merges NUM_IN commit streams into one registered writeback
// beat and accumulates the retired thread-instruction count.
import vx_commit_pkg::*;

module vx_commit_arb #(
  parameter int NUM_IN      = 4,
  parameter int NUM_THREADS = vx_commit_pkg::NUM_THREADS,
  parameter int XLEN        = vx_commit_pkg::XLEN,
  parameter int NW_BITS     = vx_commit_pkg::NW_BITS,
  parameter int NR_BITS     = vx_commit_pkg::NR_BITS,
  parameter int UUID_BITS   = vx_commit_pkg::UUID_BITS
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_IN-1:0]                   in_valid,
  input  logic [NUM_IN*UUID_BITS-1:0]         in_uuid,
  input  logic [NUM_IN*NW_BITS-1:0]           in_wid,
  input  logic [NUM_IN*NUM_THREADS-1:0]       in_tmask,
  input  logic [NUM_IN*XLEN-1:0]              in_PC,
  input  logic [NUM_IN*NUM_THREADS*XLEN-1:0]  in_data,
  input  logic [NUM_IN*NR_BITS-1:0]           in_rd,
  input  logic [NUM_IN-1:0]                   in_wb,
  input  logic [NUM_IN-1:0]                   in_eop,
  output logic [NUM_IN-1:0]                   in_ready,
  output logic                                out_valid,
  output logic [UUID_BITS-1:0]                out_uuid,
  output logic [NW_BITS-1:0]                  out_wid,
  output logic [NUM_THREADS-1:0]              out_tmask,
  output logic [XLEN-1:0]                     out_PC,
  output logic [NUM_THREADS*XLEN-1:0]         out_data,
  output logic [NR_BITS-1:0]                  out_rd,
  output logic                                out_wb,
  output logic                                out_eop,
  input  logic                                out_ready,
  output logic [63:0]                         instret
);

  // Handshake: a beat moves when valid && ready are both high at a rising edge.
  // in_ready never depends on in_valid of the same stream beyond arbitration,
  // and out_valid/payload hold steady until out_ready accepts them.
  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int DW    = NUM_THREADS * XLEN;

  logic [IDX_W-1:0]  rr_ptr;
  logic [NUM_IN-1:0] grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              free;
  logic              fire_in;
  logic              drain;
  logic              out_valid_q;
  logic [63:0]       instret_q;
  commit_t           sel;
  commit_t           out_q;
  int                gi;

  vx_rr_arbiter #(.NUM_REQS(NUM_IN)) u_arb (
    .req       (in_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign free     = !out_valid_q || out_ready;
  assign in_ready = reset ? (grant & {NUM_IN{free}}) : '0;
  assign fire_in  = |(in_valid & in_ready);
  assign drain    = out_valid_q && out_ready;

  always_comb begin
    gi        = int'(grant_idx);
    sel       = '0;
    sel.uuid  = in_uuid[gi*UUID_BITS +: UUID_BITS];
    sel.wid   = in_wid[gi*NW_BITS +: NW_BITS];
    sel.tmask = in_tmask[gi*NUM_THREADS +: NUM_THREADS];
    sel.PC    = in_PC[gi*XLEN +: XLEN];
    sel.data  = in_data[gi*DW +: DW];
    sel.rd    = in_rd[gi*NR_BITS +: NR_BITS];
    sel.wb    = in_wb[gi];
    sel.eop   = in_eop[gi];
  end

  // A drain and a fire in the same cycle simply reload the register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      rr_ptr      <= IDX_W'(NUM_IN - 1);
    end else if (fire_in) begin
      out_valid_q <= 1'b1;
      out_q       <= sel;
      rr_ptr      <= grant_idx;
    end else if (drain) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret_q <= '0;
    end else if (drain && out_q.eop) begin
      instret_q <= instret_q + popcount_tmask(out_q.tmask);
    end
  end

  assign out_valid = out_valid_q;
  assign out_uuid  = out_q.uuid;
  assign out_wid   = out_q.wid;
  assign out_tmask = out_q.tmask;
  assign out_PC    = out_q.PC;
  assign out_data  = out_q.data;
  assign out_rd    = out_q.rd;
  assign out_wb    = out_q.wb;
  assign out_eop   = out_q.eop;
  assign instret   = instret_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset && (|in_valid)) begin
      assert ($onehot(grant));
    end
  end
`endif

endmodule

// File: tb/tb_vx_commit_arb.sv
// Directed bench for vx_commit_arb: reset, single beat, round-robin order,
// back-pressure, eop-gated instret, counter wrap and async reset.
module tb_vx_commit_arb;

  logic          clk;
  logic          reset;
  logic [3:0]    in_valid;
  logic [175:0]  in_uuid;
  logic [7:0]    in_wid;
  logic [15:0]   in_tmask;
  logic [127:0]  in_PC;
  logic [511:0]  in_data;
  logic [23:0]   in_rd;
  logic [3:0]    in_wb;
  logic [3:0]    in_eop;
  logic [3:0]    in_ready;
  logic          out_valid;
  logic [43:0]   out_uuid;
  logic [1:0]    out_wid;
  logic [3:0]    out_tmask;
  logic [31:0]   out_PC;
  logic [127:0]  out_data;
  logic [5:0]    out_rd;
  logic          out_wb;
  logic          out_eop;
  logic          out_ready;
  logic [63:0]   instret;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [43:0] exp_q[$];

  vx_commit_arb dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_uuid(in_uuid), .in_wid(in_wid), .in_tmask(in_tmask),
    .in_PC(in_PC), .in_data(in_data), .in_rd(in_rd), .in_wb(in_wb), .in_eop(in_eop),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_uuid(out_uuid), .out_wid(out_wid), .out_tmask(out_tmask),
    .out_PC(out_PC), .out_data(out_data), .out_rd(out_rd), .out_wb(out_wb), .out_eop(out_eop),
    .out_ready(out_ready), .instret(instret)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, required completion");
    $fatal(1);
  end

  // drivers
  task automatic set_stream(input int s, input logic v, input logic [43:0] uuid,
                            input logic [3:0] tmask, input logic eop);
    in_valid[s]          = v;
    in_uuid[s*44 +: 44]  = uuid;
    in_wid[s*2 +: 2]     = 2'(s);
    in_tmask[s*4 +: 4]   = tmask;
    in_PC[s*32 +: 32]    = 32'h1000 + 32'(s*4);
    in_data[s*128 +: 128] = {4{uuid[31:0]}};
    in_rd[s*6 +: 6]      = 6'(s + 1);
    in_wb[s]             = (s != 1);
    in_eop[s]            = eop;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid  = '0;
    out_ready = 1'b1;
    reset     = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 4; s++) set_stream(s, 1'b1, 44'(s + 1), 4'hF, 1'b1);
    #12;
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    vec_cnt++; if (out_uuid !== 44'd0) begin err_cnt++; $display("FAIL rst_out_uuid: got %0d want 0", out_uuid); end
    vec_cnt++; if (out_data !== 128'd0) begin err_cnt++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    vec_cnt++; if (instret !== 64'd0) begin err_cnt++; $display("FAIL rst_instret: got %0d want 0", instret); end
    vec_cnt++; if (dut.rr_ptr !== 2'd3) begin err_cnt++; $display("FAIL rst_rr_ptr: got %0d want 3", dut.rr_ptr); end
    vec_cnt++; if (in_ready !== 4'b0000) begin err_cnt++; $display("FAIL rst_in_ready: got %b want 0000", in_ready); end
    @(negedge clk);
    in_valid = '0;
    reset    = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    out_ready = 1'b1;
    set_stream(2, 1'b1, 44'd5, 4'b1011, 1'b1);
    #1;
    vec_cnt++; if (in_ready !== 4'b0100) begin err_cnt++; $display("FAIL t1_in_ready: got %b want 0100", in_ready); end
    @(negedge clk);
    in_valid = '0;
    vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL t1_out_valid: got %0b want 1", out_valid); end
    vec_cnt++; if (out_uuid !== 44'd5) begin err_cnt++; $display("FAIL t1_out_uuid: got %0d want 5", out_uuid); end
    vec_cnt++; if (out_tmask !== 4'b1011) begin err_cnt++; $display("FAIL t1_out_tmask: got %b want 1011", out_tmask); end
    vec_cnt++; if (out_wid !== 2'd2) begin err_cnt++; $display("FAIL t1_out_wid: got %0d want 2", out_wid); end
    vec_cnt++; if (out_PC !== 32'h1008) begin err_cnt++; $display("FAIL t1_out_PC: got %h want 1008", out_PC); end
    vec_cnt++; if (out_rd !== 6'd3) begin err_cnt++; $display("FAIL t1_out_rd: got %0d want 3", out_rd); end
    vec_cnt++; if (out_data !== {4{32'd5}}) begin err_cnt++; $display("FAIL t1_out_data: got %h want 4x5", out_data); end
    vec_cnt++; if ({out_wb, out_eop} !== 2'b11) begin err_cnt++; $display("FAIL t1_wb_eop: got %b want 11", {out_wb, out_eop}); end
    vec_cnt++; if (instret !== 64'd0) begin err_cnt++; $display("FAIL t1_instret_pre: got %0d want 0", instret); end
    @(negedge clk);
    vec_cnt++; if (instret !== 64'd3) begin err_cnt++; $display("FAIL t1_instret: got %0d want 3", instret); end
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL t1_drained: got %0b want 0", out_valid); end
  endtask

  task automatic test_round_robin();
    logic [43:0] e;
    do_reset();
    @(negedge clk);
    for (int s = 0; s < 4; s++) set_stream(s, 1'b1, 44'(100 + s), 4'hF, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        @(negedge clk);
        e = exp_q.pop_front();
        vec_cnt++; if (out_valid !== 1'b1 || out_uuid !== e) begin err_cnt++; $display("FAIL rr_out k=%0d: got v=%0b uuid=%0d want v=1 uuid=%0d", k, out_valid, out_uuid, e); end
        vec_cnt++; if (out_wb !== (e != 44'd101)) begin err_cnt++; $display("FAIL rr_wb k=%0d: got %0b want %0b", k, out_wb, (e != 44'd101)); end
      end
      #1;
      vec_cnt++; if (in_ready !== 4'(1 << (k % 4))) begin err_cnt++; $display("FAIL rr_grant k=%0d: got %b want %b", k, in_ready, 4'(1 << (k % 4))); end
      exp_q.push_back(44'(100 + (k % 4)));
    end
    @(negedge clk);
    in_valid = '0;
    e = exp_q.pop_front();
    vec_cnt++; if (out_valid !== 1'b1 || out_uuid !== e) begin err_cnt++; $display("FAIL rr_last: got v=%0b uuid=%0d want v=1 uuid=%0d", out_valid, out_uuid, e); end
    @(negedge clk);
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL rr_idle: got %0b want 0", out_valid); end
    vec_cnt++; if (instret !== 64'd0) begin err_cnt++; $display("FAIL rr_instret: got %0d want 0", instret); end
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge clk);
    out_ready = 1'b0;
    set_stream(1, 1'b1, 44'd11, 4'b1011, 1'b1);
    set_stream(3, 1'b1, 44'd33, 4'hF, 1'b0);
    #1;
    vec_cnt++; if (in_ready !== 4'b0010) begin err_cnt++; $display("FAIL bp_first_grant: got %b want 0010", in_ready); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vec_cnt++; if (out_valid !== 1'b1 || out_uuid !== 44'd11) begin err_cnt++; $display("FAIL bp_hold c=%0d: got v=%0b uuid=%0d want v=1 uuid=11", c, out_valid, out_uuid); end
      vec_cnt++; if (in_ready !== 4'b0000) begin err_cnt++; $display("FAIL bp_in_ready c=%0d: got %b want 0000", c, in_ready); end
      vec_cnt++; if (dut.rr_ptr !== 2'd1) begin err_cnt++; $display("FAIL bp_rr_ptr c=%0d: got %0d want 1", c, dut.rr_ptr); end
      vec_cnt++; if (instret !== 64'd0) begin err_cnt++; $display("FAIL bp_instret c=%0d: got %0d want 0", c, instret); end
    end
    out_ready = 1'b1;
    #1;
    vec_cnt++; if (in_ready !== 4'b1000) begin err_cnt++; $display("FAIL bp_release_grant: got %b want 1000", in_ready); end
    @(negedge clk);
    in_valid = '0;
    vec_cnt++; if (out_valid !== 1'b1 || out_uuid !== 44'd33) begin err_cnt++; $display("FAIL bp_reload: got v=%0b uuid=%0d want v=1 uuid=33", out_valid, out_uuid); end
    vec_cnt++; if (instret !== 64'd3) begin err_cnt++; $display("FAIL bp_drain_count: got %0d want 3", instret); end
    vec_cnt++; if (dut.rr_ptr !== 2'd3) begin err_cnt++; $display("FAIL bp_rr_ptr_after: got %0d want 3", dut.rr_ptr); end
    @(negedge clk);
  endtask

  task automatic test_eop();
    do_reset();
    @(negedge clk);
    set_stream(0, 1'b1, 44'd40, 4'hF, 1'b0);
    @(negedge clk);
    set_stream(0, 1'b1, 44'd41, 4'hF, 1'b0);
    @(negedge clk);
    vec_cnt++; if (instret !== 64'd0) begin err_cnt++; $display("FAIL eop_mid: got %0d want 0", instret); end
    set_stream(0, 1'b1, 44'd42, 4'h3, 1'b1);
    @(negedge clk);
    in_valid = '0;
    vec_cnt++; if (instret !== 64'd0) begin err_cnt++; $display("FAIL eop_pre: got %0d want 0", instret); end
    @(negedge clk);
    vec_cnt++; if (instret !== 64'd2) begin err_cnt++; $display("FAIL eop_count: got %0d want 2", instret); end
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk);
    set_stream(0, 1'b1, 44'd50, 4'hF, 1'b1);
    @(negedge clk);
    in_valid = '0;
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    release dut.instret_q;
    #1;
    vec_cnt++; if (instret !== 64'hFFFF_FFFF_FFFF_FFFE) begin err_cnt++; $display("FAIL wrap_preload: got %h want fffffffffffffffe", instret); end
    @(negedge clk);
    vec_cnt++; if (instret !== 64'd2) begin err_cnt++; $display("FAIL wrap_count: got %h want 2", instret); end
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk);
    set_stream(2, 1'b1, 44'd60, 4'hF, 1'b1);
    @(negedge clk);
    set_stream(2, 1'b1, 44'd61, 4'hF, 1'b1);
    @(negedge clk);
    in_valid  = '0;
    out_ready = 1'b0;
    vec_cnt++; if (instret !== 64'd4 || out_uuid !== 44'd61 || out_valid !== 1'b1) begin err_cnt++; $display("FAIL ar_setup: got instret=%0d uuid=%0d v=%0b want 4 61 1", instret, out_uuid, out_valid); end
    #2;
    reset = 1'b0;
    #1;
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL ar_out_valid: got %0b want 0", out_valid); end
    vec_cnt++; if (instret !== 64'd0) begin err_cnt++; $display("FAIL ar_instret: got %0d want 0", instret); end
    vec_cnt++; if (out_uuid !== 44'd0) begin err_cnt++; $display("FAIL ar_out_uuid: got %0d want 0", out_uuid); end
    for (int s = 0; s < 4; s++) set_stream(s, 1'b1, 44'(70 + s), 4'hF, 1'b0);
    #1;
    vec_cnt++; if (in_ready !== 4'b0000) begin err_cnt++; $display("FAIL ar_in_ready: got %b want 0000", in_ready); end
    @(negedge clk);
    reset     = 1'b1;
    out_ready = 1'b1;
    #1;
    vec_cnt++; if (in_ready !== 4'b0001) begin err_cnt++; $display("FAIL ar_first_grant: got %b want 0001", in_ready); end
    @(negedge clk);
    in_valid = '0;
    vec_cnt++; if (out_valid !== 1'b1 || out_uuid !== 44'd70) begin err_cnt++; $display("FAIL ar_first_beat: got v=%0b uuid=%0d want v=1 uuid=70", out_valid, out_uuid); end
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b0;
    out_ready = 1'b1;
    in_valid  = '0;
    in_uuid   = '0;
    in_wid    = '0;
    in_tmask  = '0;
    in_PC     = '0;
    in_data   = '0;
    in_rd     = '0;
    in_wb     = '0;
    in_eop    = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_eop();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
